fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to code memory and buffers
// {pc, instruction} pairs in a small FIFO toward decode, with redirect flushing.
module fetch_unit #(
    parameter int PC_W   = 30,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    output logic                   imem_en,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic [PC_W-1:0]        inst_pc,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]  r_fetch_pc;
    logic             r_inflight;
    logic [PC_W-1:0]  r_inflight_pc;
    logic             r_inflight_epoch;
    logic             r_epoch;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  r_fifo_pc   [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];

    logic [CNT_W:0]   w_used;
    logic             w_enq;
    logic             w_deq;

    // Entries already queued plus the one in flight must leave room for a new issue.
    assign w_used    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign imem_en   = ~resetn & ~redirect_valid & (w_used < DEPTH_L);
    assign imem_addr = r_fetch_pc[ADDR_W-1:0];

    // A response from an older epoch, or one landing during a flush, is dropped.
    assign w_enq = r_inflight & (r_inflight_epoch == r_epoch) & ~redirect_valid;
    assign w_deq = inst_valid & inst_ready;

    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign occupancy  = r_count;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_fetch_pc       <= '0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_epoch    <= ~r_epoch;
            end else begin
                if (imem_en) r_fetch_pc <= r_fetch_pc + PC_W'(1);
                if (w_enq)   r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                if (w_deq)   r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
            r_inflight <= imem_en;
            if (imem_en) r_inflight_epoch <= r_epoch;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_en) r_inflight_pc <= r_fetch_pc;
        if (w_enq) begin
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
            r_fifo_data[r_wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        imem_en;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [29:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_pc = '0;
    logic [2:0]  occupancy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [29:0] m_pc;
    logic [29:0] m_q[$];
    bit          m_infl;
    logic [29:0] m_infl_pc;
    logic [29:0] got[$];

    fetch_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Code memory: word k holds 0x1000_0000 + k, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + {25'd0, imem_addr};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] exp_data(logic [29:0] pc);
        return 32'h1000_0000 + {25'd0, pc[6:0]};
    endfunction

    function automatic bit model_en();
        return !resetn && !redirect_valid && (m_q.size() + int'(m_infl) < 4);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pc = '0;
        m_q.delete();
        m_infl = 0;
        m_infl_pc = '0;
    endtask

    // Compare all outputs with the model at the falling edge.
    task automatic sample();
        @(negedge clk);
        check("m_valid", 64'(inst_valid), 64'(m_q.size() > 0));
        check("m_occ", 64'(occupancy), 64'(m_q.size()));
        check("m_en", 64'(imem_en), 64'(model_en()));
        if (model_en()) check("m_addr", 64'(imem_addr), 64'(m_pc[6:0]));
        if (m_q.size() > 0) begin
            check("m_pc", 64'(inst_pc), 64'(m_q[0]));
            check("m_data", 64'(inst_data), 64'(exp_data(m_q[0])));
        end
    endtask

    // Advance one clock and apply the same rules to the model.
    task automatic tick();
        bit en;
        bit deq;
        @(posedge clk);
        en  = model_en();
        deq = (m_q.size() > 0) && inst_ready;
        if (resetn) begin
            model_clear();
        end else if (redirect_valid) begin
            m_q.delete();
            m_infl = 0;
            m_pc = redirect_pc;
        end else begin
            if (deq) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = en;
            if (en) begin
                m_infl_pc = m_pc;
                m_pc = m_pc + 30'd1;
            end
        end
        #1;
    endtask

    // Assert reset asynchronously, check outputs before any edge, then release.
    task automatic apply_reset();
        resetn = 1'b1;
        #1;
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_en", 64'(imem_en), 64'd0);
        check("rst_data", 64'(inst_data), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        resetn = 1'b0;
    endtask

    initial begin
        #3;
        // Reset release and streaming
        apply_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c == 0) check("s1_issue0", 64'(imem_en), 64'd1);
            if (c < 2) check("s1_latency", 64'(inst_valid), 64'd0);
            else begin
                check("s1_valid", 64'(inst_valid), 64'd1);
                check("s1_pc", 64'(inst_pc), 64'(c - 2));
            end
            tick();
        end

        // Backpressure fills the queue
        apply_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c >= 4) check("s2_en_low", 64'(imem_en), 64'd0);
            if (c == 9) check("s2_occ_full", 64'(occupancy), 64'd4);
            tick();
        end
        inst_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 4; c++) begin
            sample();
            if (inst_valid) got.push_back(inst_pc);
            tick();
        end
        check("s2_npop", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) check("s2_order", 64'(got[i]), 64'(i));

        // Redirect while the queue is full
        apply_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 30'h40;
        inst_ready = 1'b1;
        sample();
        tick();
        redirect_valid = 1'b0;
        for (int c = 7; c < 13; c++) begin
            sample();
            if (inst_valid) check("s3_stale", 64'(inst_pc >= 30'h40), 64'd1);
            if (c < 9) check("s3_gap", 64'(inst_valid), 64'd0);
            if (c == 9) begin
                check("s3_valid", 64'(inst_valid), 64'd1);
                check("s3_pc", 64'(inst_pc), 64'h40);
            end
            tick();
        end

        // Redirect with handshake, then a second redirect
        apply_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 30'h20;
        sample();
        check("s4_handshake", 64'(inst_valid && inst_ready), 64'd1);
        tick();
        redirect_pc = 30'h80;
        sample();
        tick();
        redirect_valid = 1'b0;
        for (int c = 6; c < 12; c++) begin
            sample();
            if (inst_valid) check("s4_first_target", 64'(inst_pc != 30'h20), 64'd1);
            if (c < 8) check("s4_gap", 64'(inst_valid), 64'd0);
            if (c == 8) begin
                check("s4_valid", 64'(inst_valid), 64'd1);
                check("s4_pc", 64'(inst_pc), 64'h80);
            end
            tick();
        end

        // Address wrap versus full PC
        apply_reset();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 30'h7F;
        for (int c = 0; c < 5; c++) begin
            sample();
            case (c)
                0: check("s5_no_issue", 64'(imem_en), 64'd0);
                1: check("s5_addr7f", 64'({imem_en, imem_addr}), 64'h0FF);
                2: check("s5_addr00", 64'({imem_en, imem_addr}), 64'h080);
                3: begin
                    check("s5_pc7f", 64'(inst_pc), 64'h7F);
                    check("s5_data7f", 64'(inst_data), 64'h1000_007F);
                end
                default: begin
                    check("s5_pc80", 64'(inst_pc), 64'h80);
                    check("s5_data80", 64'(inst_data), 64'h1000_0000);
                end
            endcase
            tick();
            redirect_valid = 1'b0;
        end

        // Asynchronous reset mid-stream
        apply_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sample();
            tick();
        end
        sample();
        #2;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            sample();
            if (c == 0) check("s6_restart", 64'({imem_en, imem_addr}), 64'h080);
            if (c >= 2) check("s6_pc", 64'(inst_pc), 64'(c - 2));
            tick();
        end

        // Random ready and redirect traffic
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
            sample();
            tick();
        end
        redirect_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
